// File: rtl/matriz_pkg.sv
// Shared constants and helpers for the 5x5 matrix datapath (loader and determinant units).
// The element packing helper is shared so that every unit agrees on the bit layout.
package matriz_pkg;

    localparam int DIM    = 5;
    localparam int ELEM_W = 8;
    localparam int ELEMS  = DIM * DIM;
    localparam int MAT_W  = ELEMS * ELEM_W;
    localparam int CNT_W  = $clog2(ELEMS + 1);

    // Observable loader condition, decoded from the counter and the output flag.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILL,
        ST_HOLD,
        ST_STALL
    } load_state_t;

    // MSB position of row-major element k inside the packed matrix (element 0 on top).
    function automatic int elem_msb(input int k);
        return MAT_W - 1 - k * ELEM_W;
    endfunction

endpackage

// File: rtl/matrix_loader_5x5_if.sv
// Element stream in, packed matrix out, plus the abort and fill-level side signals.
// The slave modport is the loader; the master modport is whoever feeds and drains it.
interface matrix_loader_5x5_if;
    import matriz_pkg::*;

    logic                     clear;
    logic                     in_valid;
    logic signed [ELEM_W-1:0] in_data;
    logic                     in_ready;
    logic        [MAT_W-1:0]  matriz_out;
    logic                     matriz_valid;
    logic                     matriz_ready;
    logic        [CNT_W-1:0]  elem_count;

    modport slave (
        input  clear,
        input  in_valid,
        input  in_data,
        input  matriz_ready,
        output in_ready,
        output matriz_out,
        output matriz_valid,
        output elem_count
    );

    modport master (
        output clear,
        output in_valid,
        output in_data,
        output matriz_ready,
        input  in_ready,
        input  matriz_out,
        input  matriz_valid,
        input  elem_count
    );

endinterface

// File: rtl/matrix_loader_5x5.sv
// Collects 25 row-major signed elements into a shadow buffer and presents them as one packed
// matrix; the next matrix fills while the previous one waits for the consumer.
module matrix_loader_5x5
    import matriz_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    matrix_loader_5x5_if.slave bus
);

    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic [MAT_W-1:0]  mat_q, mat_d;
    logic [MAT_W-1:0]  full_mat;
    logic [ELEM_W-1:0] shadow_q [ELEMS-1];
    logic [ELEM_W-1:0] shadow_d [ELEMS-1];

    load_state_t state;
    logic        last_slot;
    logic        in_ready;
    logic        accept;

    assign last_slot = (count_q == CNT_W'(ELEMS - 1));

    always_comb begin
        state = ST_EMPTY;
        if (valid_q && last_slot && !bus.matriz_ready) begin
            state = ST_STALL;
        end else if (valid_q) begin
            state = ST_HOLD;
        end else if (count_q != '0) begin
            state = ST_FILL;
        end
    end

    // Only the final beat can be refused: it would overwrite a matrix nobody has taken yet.
    assign in_ready = (state != ST_STALL);
    assign accept   = bus.in_valid && in_ready && !bus.clear;

    // The last element bypasses the shadow buffer and goes straight into the output word.
    generate
        for (genvar gi = 0; gi < ELEMS - 1; gi++) begin : g_pack
            assign full_mat[elem_msb(gi) -: ELEM_W] = shadow_q[gi];
        end
    endgenerate
    assign full_mat[ELEM_W-1:0] = bus.in_data;

    always_comb begin
        count_d  = count_q;
        valid_d  = valid_q;
        mat_d    = mat_q;
        shadow_d = shadow_q;
        if (bus.clear) begin
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            if (valid_q && bus.matriz_ready) begin
                valid_d = 1'b0;
            end
            if (accept) begin
                if (last_slot) begin
                    count_d = '0;
                    mat_d   = full_mat;
                    valid_d = 1'b1;
                end else begin
                    shadow_d[count_q] = bus.in_data;
                    count_d           = count_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            valid_q <= 1'b0;
            mat_q   <= '0;
            for (int i = 0; i < ELEMS - 1; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            valid_q  <= valid_d;
            mat_q    <= mat_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.matriz_out   = mat_q;
    assign bus.matriz_valid = valid_q;
    assign bus.elem_count   = count_q;

endmodule

// File: tb/tb_matrix_loader_5x5.sv
// Self-checking bench for matrix_loader_5x5: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the loader.
module tb_matrix_loader_5x5;
    import matriz_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_loader_5x5_if bus();

    matrix_loader_5x5 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_mat = 0;

    // Model: elements waiting for completion, and the matrix currently offered downstream.
    int               m_q[$];
    bit               m_valid;
    logic [MAT_W-1:0] m_mat;

    task automatic check_eq(input string tag, input logic [MAT_W-1:0] got,
                            input logic [MAT_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_in_ready(input bit rdy);
        return !(m_q.size() == ELEMS - 1 && m_valid && !rdy);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_valid = 1'b0;
        m_mat   = '0;
    endtask

    // One clock cycle: drive inputs, check all outputs against the model, then advance the model.
    task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        bit acc;
        bit cons;
        @(negedge clk);
        bus.in_valid     = v;
        bus.in_data      = d;
        bus.matriz_ready = rdy;
        bus.clear        = clr;
        #1;
        check_eq("in_ready",     MAT_W'(bus.in_ready),     MAT_W'(m_in_ready(rdy)));
        check_eq("matriz_valid", MAT_W'(bus.matriz_valid), MAT_W'(m_valid));
        check_eq("elem_count",   MAT_W'(bus.elem_count),   MAT_W'(m_q.size()));
        check_eq("matriz_out",   bus.matriz_out,           m_mat);
        acc  = v && m_in_ready(rdy);
        cons = m_valid && rdy;
        @(posedge clk);
        if (clr) begin
            m_q.delete();
            m_valid = 1'b0;
        end else begin
            if (cons) m_valid = 1'b0;
            if (acc) begin
                m_q.push_back(int'(d));
                if (m_q.size() == ELEMS) begin
                    for (int k = 0; k < ELEMS; k++) begin
                        m_mat[MAT_W-1-k*ELEM_W -: ELEM_W] = ELEM_W'(m_q[k]);
                    end
                    m_q.delete();
                    m_valid = 1'b1;
                    n_mat++;
                    $display("matrix %0d complete: first=%0d last=%0d", n_mat,
                             $signed(m_mat[MAT_W-1 -: ELEM_W]), $signed(m_mat[ELEM_W-1:0]));
                end
            end
        end
    endtask

    logic [MAT_W-1:0] snap;

    initial begin
        rst              = 1'b1;
        bus.clear        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.matriz_ready = 1'b0;
        m_reset();
        #3;
        check_eq("rst_valid", MAT_W'(bus.matriz_valid), '0);
        check_eq("rst_count", MAT_W'(bus.elem_count),   '0);
        check_eq("rst_out",   bus.matriz_out,           '0);
        @(negedge clk);
        rst = 1'b0;

        // Stream 1..25, then hold so the result can be inspected.
        step(1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= ELEMS; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        #1;
        check_eq("seq_first", MAT_W'(bus.matriz_out[MAT_W-1 -: ELEM_W]), MAT_W'(8'd1));
        check_eq("seq_last",  MAT_W'(bus.matriz_out[ELEM_W-1:0]),        MAT_W'(8'd25));

        // Identity matrix, then a second matrix starting with -128.
        step(1'b0, 8'd0, 1'b1, 1'b0);
        for (int k = 0; k < ELEMS; k++) step(1'b1, (k % (DIM + 1) == 0) ? 8'd1 : 8'd0, 1'b1, 1'b0);
        step(1'b1, 8'h80, 1'b1, 1'b0);
        for (int k = 1; k < ELEMS; k++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        #1;
        check_eq("neg_first", MAT_W'(bus.matriz_out[MAT_W-1 -: ELEM_W]), MAT_W'(8'h80));

        // Back-to-back 50 beats with a consumer that never stalls.
        step(1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 2 * ELEMS; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);

        // Blocked consumer: the 50th beat stalls until matriz_ready rises.
        for (int i = 0; i < 2 * ELEMS - 1; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        snap = bus.matriz_out;
        for (int i = 0; i < 3; i++) step(1'b1, 8'h5a, 1'b0, 1'b0);
        check_eq("stall_hold", bus.matriz_out, snap);
        step(1'b1, 8'h5a, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);

        // Partial load aborted by clear while an element is offered.
        step(1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        for (int i = 0; i < ELEMS; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);

        // Asynchronous reset in HOLD with seven elements in the shadow buffer.
        step(1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < ELEMS + 7; i++) step(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", MAT_W'(bus.matriz_valid), '0);
        check_eq("arst_count", MAT_W'(bus.elem_count),   '0);
        check_eq("arst_out",   bus.matriz_out,           '0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic, including occasional clears and consumer back-pressure.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) < 8), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 99) < 2));
        end
        step(1'b0, 8'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
